// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Single-port DEPTH x DATA_WIDTH data memory serving CPU load/store traffic.
// Each request is accepted in IDLE. The FSM then spends one cycle in RESP,
// where it drives a single-cycle ack. Reads return registered data that is
// valid in the ack cycle.
//
// Optional feature macro: DATA_MEMORY_CLEAR_ON_RESET_EN
//   defined   : after reset an INIT pass writes 0 to every word, one word per
//               cycle, with busy high. Requests are ignored until it finishes.
//   undefined : IDLE is entered straight from reset, busy is tied low, and
//               the array contents are whatever was left in it.
//
// Ports:
//   clk               - clock, rising edge active
//   rst_n             - asynchronous active-low reset
//   req               - transaction request (sampled in IDLE only)
//   read_write_memory - 1 = write, 0 = read (sampled with req)
//   addr              - word address (sampled with req)
//   data_out_memory   - write data from the CPU (sampled with req)
//   data_in_memory    - registered read data to the CPU
//   ack               - one-cycle completion pulse
//   busy              - high while the clear sequence is running
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  read_write_memory,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_out_memory,
    output logic [DATA_WIDTH-1:0] data_in_memory,
    output logic                  ack,
    output logic                  busy
);

`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;
    localparam state_t             RESET_STATE = INIT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    logic [ADDR_WIDTH-1:0] clr_cnt;
`else
    typedef enum logic {IDLE, RESP} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
            INIT:    if (clr_cnt == LAST_ADDR) state_d = IDLE;
`endif
            IDLE:    if (req) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and memory-port decode.
    always_comb begin
        ack       = 1'b0;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_out_memory;
        rd_en     = 1'b0;
        case (state_q)
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
            INIT: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = '0;
            end
`endif
            IDLE: begin
                if (req) begin
                    mem_we = read_write_memory;
                    rd_en  = !read_write_memory;
                end
            end
            RESP:    ack = 1'b1;
            default: ;
        endcase
    end

`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
    // Clear address. It only advances in INIT. After the last word it wraps
    // back to 0, which leaves it ready for the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state_q == INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`endif

    // Storage array.
    // NOTE: the array has no reset, so it maps onto RAM macros. Zeroing it is
    // the job of the optional INIT pass, not of rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read data register. It holds its value until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in_memory <= '0;
        end else if (rd_en) begin
            data_in_memory <= mem[addr];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
    localparam int CLEAR_EDGES = 512;
    localparam logic [15:0] AFTER_RESET_005 = 16'h0000;
`else
    localparam int CLEAR_EDGES = 0;
    localparam logic [15:0] AFTER_RESET_005 = 16'h1234;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        read_write_memory = 1'b0;
    logic [8:0]  addr = '0;
    logic [15:0] data_out_memory = '0;
    logic [15:0] data_in_memory;
    logic        ack;
    logic        busy;

    int total = 0;
    int bad   = 0;

    data_memory dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req),
        .read_write_memory (read_write_memory),
        .addr              (addr),
        .data_out_memory   (data_out_memory),
        .data_in_memory    (data_in_memory),
        .ack               (ack),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges while busy is high, with a bound.
    task automatic count_busy(input string tag);
        int edges = 0;
        while (busy === 1'b1 && edges < 600) begin
            tick();
            edges++;
        end
        check(tag, edges, CLEAR_EDGES);
    endtask

    // Issues one transaction. The task is entered just after an edge with
    // the FSM in IDLE and returns just after the edge back into IDLE.
    task automatic do_write(input string tag, input logic [8:0] a, input logic [15:0] d,
                            input logic [15:0] exp_rdata);
        req = 1'b1; read_write_memory = 1'b1; addr = a; data_out_memory = d;
        tick();
        req = 1'b0; read_write_memory = 1'b0;
        check({tag, "_ack"}, ack, 1'b1);
        check({tag, "_rdata_held"}, data_in_memory, exp_rdata);
        tick();
        check({tag, "_ack_low"}, ack, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [8:0] a, input logic [15:0] exp);
        req = 1'b1; read_write_memory = 1'b0; addr = a;
        tick();
        req = 1'b0;
        check({tag, "_ack"}, ack, 1'b1);
        check({tag, "_data"}, data_in_memory, exp);
        tick();
    endtask

    initial begin
        int acks;
        logic exp_ack;

        // Reset values.
        #12;
        check("rst_ack", ack, 1'b0);
        check("rst_data", data_in_memory, 16'h0000);
        check("rst_busy", busy, CLEAR_EDGES != 0);

        // Test 1: release reset between edges, then time the clear pass.
        @(posedge clk); #2;
        rst_n = 1'b1;
        count_busy("clear_edges");
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
        do_read("rd_1ff_clear", 9'h1FF, 16'h0000);
`endif

        // Test 2 (and test 6 when clear is off): write accepted on the first edge.
        do_write("wr_005", 9'h005, 16'h1234, 16'h0000);
        do_read("rd_005", 9'h005, 16'h1234);
        do_write("wr_006", 9'h006, 16'hBEEF, 16'h1234);
        do_write("wr_010", 9'h010, 16'h00A5, 16'h1234);
        do_read("rd_010", 9'h010, 16'h00A5);
        do_read("rd_006", 9'h006, 16'hBEEF);
        do_read("rd_005b", 9'h005, 16'h1234);

        // Test 3: req held high for 6 cycles.
        acks = 0;
        req = 1'b1; read_write_memory = 1'b0; addr = 9'h005;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ack = (i % 2) == 0;
            check($sformatf("stream_ack%0d", i), ack, exp_ack);
            if (ack === 1'b1) acks++;
        end
        req = 1'b0;
        check("stream_count", acks, 3);
        check("stream_data", data_in_memory, 16'h1234);

        // Test 4: the boundary addresses.
        do_write("wr_1ff", 9'h1FF, 16'hFFFF, 16'h1234);
        do_write("wr_000", 9'h000, 16'h8001, 16'h1234);
        do_read("rd_1ff", 9'h1FF, 16'hFFFF);
        do_read("rd_000", 9'h000, 16'h8001);
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
        do_read("rd_1fe", 9'h1FE, 16'h0000);
        do_read("rd_001", 9'h001, 16'h0000);
`endif

        // Test 5: reset while a read is in flight.
        do_read("rd_005_pre", 9'h005, 16'h1234);
        req = 1'b1; read_write_memory = 1'b0; addr = 9'h005;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", ack, 1'b0);
        check("mid_rst_data", data_in_memory, 16'h0000);
        check("mid_rst_busy", busy, CLEAR_EDGES != 0);
        #20;
        rst_n = 1'b1;
        count_busy("reclear_edges");
        do_read("rd_005_post", 9'h005, AFTER_RESET_005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
